// File: rtl/clock_gate_ctrl_if.sv
// Handshake bundle between the clock-gate sequencer and its environment:
// activity/wake inputs and the COND register port of the gated-clock primitive.
interface clock_gate_ctrl_if #(
    parameter int NREQ = 4
);
    logic            busy;
    logic            force_on;
    logic [NREQ-1:0] wake_req;
    logic            sleep_ack;
    logic            cond;
    logic            cond_en;
    logic            sleep_req;
    logic [NREQ-1:0] wake_ack;
    logic            ready;
    logic            gated;

    modport master (
        output busy, force_on, wake_req, sleep_ack,
        input  cond, cond_en, sleep_req, wake_ack, ready, gated
    );

    modport slave (
        input  busy, force_on, wake_req, sleep_ack,
        output cond, cond_en, sleep_req, wake_ack, ready, gated
    );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Always-on sequencer that gates a clock after a programmable idle period
// (with a quiesce handshake) and re-enables it on any wake request.
module clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8,
    parameter int NREQ        = 4,
    parameter int WAKE_LAT    = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    clock_gate_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SLEEP_HS = 2'd1;
    localparam logic [1:0] ST_OFF      = 2'd2;
    localparam logic [1:0] ST_WAKING   = 2'd3;

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'(WAKE_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             cond_q, cond_d;
    logic             cond_en_q, cond_en_d;
    logic             sleep_req_q, sleep_req_d;
    logic             ready_q, ready_d;
    logic             gated_q, gated_d;
    logic             ack_en;
    logic             idle;
    logic [NREQ-1:0]  ack_d, ack_q;
    logic [NREQ-1:0]  mask_d, mask_q;

    assign idle = !bus.busy && !bus.force_on && (bus.wake_req == '0);

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        wake_cnt_d  = wake_cnt_q;
        cond_d      = cond_q;
        cond_en_d   = 1'b0;
        sleep_req_d = sleep_req_q;
        ready_d     = ready_q;
        gated_d     = gated_q;
        ack_en      = 1'b0;
        case (state_q)
            ST_RUN: begin
                ack_en = 1'b1;
                if (!idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    state_d     = ST_SLEEP_HS;
                    sleep_req_d = 1'b1;
                    idle_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_SLEEP_HS: begin
                // Losing idleness wins over a late quiesce confirmation.
                if (!idle) begin
                    state_d     = ST_RUN;
                    sleep_req_d = 1'b0;
                end else if (bus.sleep_ack) begin
                    state_d     = ST_OFF;
                    cond_d      = 1'b0;
                    cond_en_d   = 1'b1;
                    ready_d     = 1'b0;
                    gated_d     = 1'b1;
                    sleep_req_d = 1'b0;
                end
            end
            ST_OFF: begin
                // Wait out the gating write so COND_EN never strobes back-to-back.
                if (!cond_en_q && ((bus.wake_req != '0) || bus.force_on)) begin
                    state_d    = ST_WAKING;
                    cond_d     = 1'b1;
                    cond_en_d  = 1'b1;
                    gated_d    = 1'b0;
                    wake_cnt_d = WAKE_INIT;
                end
            end
            default: begin
                if (wake_cnt_q == '0) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    ack_en  = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Each requester is acked once; its mask clears only when the request drops.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign ack_d[gi]  = ack_en && bus.wake_req[gi] && !mask_q[gi];
        assign mask_d[gi] = bus.wake_req[gi] && (mask_q[gi] || ack_d[gi]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ack_q[gi]  <= 1'b0;
                mask_q[gi] <= 1'b0;
            end else begin
                ack_q[gi]  <= ack_d[gi];
                mask_q[gi] <= mask_d[gi];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            cond_q      <= 1'b1;
            cond_en_q   <= 1'b0;
            sleep_req_q <= 1'b0;
            ready_q     <= 1'b1;
            gated_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            cond_q      <= cond_d;
            cond_en_q   <= cond_en_d;
            sleep_req_q <= sleep_req_d;
            ready_q     <= ready_d;
            gated_q     <= gated_d;
        end
    end

    assign bus.cond      = cond_q;
    assign bus.cond_en   = cond_en_q;
    assign bus.sleep_req = sleep_req_q;
    assign bus.wake_ack  = ack_q;
    assign bus.ready     = ready_q;
    assign bus.gated     = gated_q;
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed vector table, two hand sequences
// (idle-counter restart, reset during wake) and randomized traffic vs a model.
module tb_clock_gate_ctrl;
    localparam int IDLE_CYCLES = 16;
    localparam int CNT_W       = 8;
    localparam int NREQ        = 4;
    localparam int WAKE_LAT    = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    clock_gate_ctrl_if #(.NREQ(NREQ)) bus ();

    clock_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .CNT_W(CNT_W),
        .NREQ(NREQ),
        .WAKE_LAT(WAKE_LAT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {cond, cond_en, sleep_req, ready, gated, wake_ack[3:0]}
    function automatic logic [8:0] outs();
        return {bus.cond, bus.cond_en, bus.sleep_req, bus.ready, bus.gated, bus.wake_ack};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cond/en/sreq/rdy/gated/ack=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic f, input logic [3:0] r, input logic s);
        bus.busy      = b;
        bus.force_on  = f;
        bus.wake_req  = r;
        bus.sleep_ack = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_AWAKE, P_ASKING, P_ASLEEP, P_RESUMING} phase_t;
    phase_t     m_ph;
    int         m_idle_run;
    int         m_resume_left;
    logic [3:0] m_acked;
    logic       e_cond, e_en, e_sreq, e_ready, e_gated;
    logic [3:0] e_ack;

    task automatic model_reset();
        m_ph = P_AWAKE; m_idle_run = 0; m_resume_left = 0; m_acked = '0;
        e_cond = 1'b1; e_en = 1'b0; e_sreq = 1'b0; e_ready = 1'b1; e_gated = 1'b0; e_ack = '0;
    endtask

    task automatic model_step(input logic b, input logic f, input logic [3:0] r, input logic s);
        logic       is_idle;
        logic       wrote_last;
        logic [3:0] ack_now;
        is_idle    = !b && !f && (r == 4'b0);
        wrote_last = e_en;
        ack_now    = '0;
        e_en       = 1'b0;
        case (m_ph)
            P_AWAKE: begin
                ack_now = r & ~m_acked;
                if (is_idle) begin
                    m_idle_run++;
                    if (m_idle_run == IDLE_CYCLES) begin
                        m_ph = P_ASKING; e_sreq = 1'b1; m_idle_run = 0;
                    end
                end else m_idle_run = 0;
            end
            P_ASKING: begin
                if (!is_idle) begin
                    m_ph = P_AWAKE; e_sreq = 1'b0;
                end else if (s) begin
                    m_ph = P_ASLEEP; e_cond = 1'b0; e_en = 1'b1;
                    e_ready = 1'b0; e_gated = 1'b1; e_sreq = 1'b0;
                end
            end
            P_ASLEEP: begin
                if (!wrote_last && (r != 4'b0 || f)) begin
                    m_ph = P_RESUMING; e_cond = 1'b1; e_en = 1'b1;
                    e_gated = 1'b0; m_resume_left = WAKE_LAT;
                end
            end
            default: begin
                m_resume_left--;
                if (m_resume_left == 0) begin
                    m_ph = P_AWAKE; e_ready = 1'b1;
                    ack_now = r & ~m_acked;
                end
            end
        endcase
        m_acked = (m_acked | ack_now) & r;
        e_ack   = ack_now;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        logic       busy;
        logic       force_on;
        logic [3:0] req;
        logic       sack;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic b, input logic f,
                                input logic [3:0] r, input logic s, input int n,
                                input logic [8:0] e);
        vec_t v;
        v.name = nm; v.busy = b; v.force_on = f; v.req = r; v.sack = s; v.n = n; v.exp = e;
        return v;
    endfunction

    initial begin
        int cyc;
        logic [3:0] rq;
        logic b, f, s;

        vecs.push_back(mk("idle15",       0, 0, 4'b0000, 0, 15, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("sreq_at16",    0, 0, 4'b0000, 0,  1, 9'b1_0_1_1_0_0000));
        vecs.push_back(mk("gate_write",   0, 0, 4'b0000, 1,  1, 9'b0_1_0_0_1_0000));
        vecs.push_back(mk("off_hold",     0, 0, 4'b0000, 0,  1, 9'b0_0_0_0_1_0000));
        vecs.push_back(mk("off_busy_ign", 1, 0, 4'b0000, 0,  3, 9'b0_0_0_0_1_0000));
        vecs.push_back(mk("wake_write",   0, 0, 4'b0101, 0,  1, 9'b1_1_0_0_0_0000));
        vecs.push_back(mk("waking",       0, 0, 4'b0101, 0,  1, 9'b1_0_0_0_0_0000));
        vecs.push_back(mk("ready_ack",    0, 0, 4'b0101, 0,  1, 9'b1_0_0_1_0_0101));
        vecs.push_back(mk("no_2nd_ack",   0, 0, 4'b0101, 0,  1, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("held_no_gate", 0, 0, 4'b0101, 0, 20, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("idle15_b",     0, 0, 4'b0000, 0, 15, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("sreq_b",       0, 0, 4'b0000, 0,  1, 9'b1_0_1_1_0_0000));
        vecs.push_back(mk("abort_prio",   1, 0, 4'b0000, 1,  1, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("run_ack3",     0, 0, 4'b1000, 0,  1, 9'b1_0_0_1_0_1000));
        vecs.push_back(mk("run_ack3_1x",  0, 0, 4'b1000, 0,  1, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("sreq_c",       0, 0, 4'b0000, 0, 16, 9'b1_0_1_1_0_0000));
        vecs.push_back(mk("gate_write_c", 0, 0, 4'b0000, 1,  1, 9'b0_1_0_0_1_0000));
        vecs.push_back(mk("force_blk_en", 0, 1, 4'b0000, 0,  1, 9'b0_0_0_0_1_0000));
        vecs.push_back(mk("force_wake",   0, 1, 4'b0000, 0,  1, 9'b1_1_0_0_0_0000));
        vecs.push_back(mk("force_ready",  0, 1, 4'b0000, 0,  2, 9'b1_0_0_1_0_0000));
        vecs.push_back(mk("force_hold",   0, 1, 4'b0000, 0, 30, 9'b1_0_0_1_0_0000));

        do_reset();
        check("reset_state", 9'b1_0_0_1_0_0000);
        foreach (vecs[i]) begin
            drive(vecs[i].busy, vecs[i].force_on, vecs[i].req, vecs[i].sack);
            repeat (vecs[i].n) tick();
            check(vecs[i].name, vecs[i].exp);
            $display("vec %0d %s: outs=%b", i, vecs[i].name, outs());
        end

        // BUSY pulse at idle count 10 restarts the idle count
        do_reset();
        repeat (10) tick();
        drive(1'b1, 1'b0, 4'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'b0, 1'b0);
        cyc = 0;
        while (!bus.sleep_req && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != IDLE_CYCLES) begin
            errors++;
            $display("FAIL busy_restart: sleep_req after %0d cycles, expected %0d", cyc, IDLE_CYCLES);
        end
        $display("seq busy_restart: sleep_req after %0d idle cycles", cyc);

        // Reset asserted in the middle of WAKING
        drive(1'b0, 1'b0, 4'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'b0001, 1'b0);
        tick();
        check("wake_write_pre_rst", 9'b1_1_0_0_0_0000);
        tick();
        check("waking_pre_rst", 9'b1_0_0_0_0_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 9'b1_0_0_1_0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_ack", 9'b1_0_0_1_0_0001);
        $display("seq reset_in_waking: outs=%b", outs());

        // Randomized traffic against the model
        do_reset();
        model_reset();
        rq = '0;
        for (int t = 0; t < 4000; t++) begin
            b = ($urandom_range(49) == 0);
            f = ($urandom_range(199) == 0);
            s = ($urandom_range(3) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!rq[k]) rq[k] = ($urandom_range(59) == 0);
                else        rq[k] = ($urandom_range(9) != 0);
            end
            drive(b, f, rq, s);
            model_step(b, f, rq, s);
            tick();
            check($sformatf("rand_%0d", t), {e_cond, e_en, e_sreq, e_ready, e_gated, e_ack});
            if (t % 500 == 0) $display("rand %0d: outs=%b", t, outs());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
